// File: rtl/auth_cmd_rx_if.sv
// rtl/auth_cmd_rx_if.sv - UART line, rider sense and authorization outputs of auth_cmd_rx
interface auth_cmd_rx_if;
  logic       RX;
  logic       rider_off;
  logic       pwr_up;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       frm_err;

  modport master (
    output RX,
    output rider_off,
    input  pwr_up,
    input  rx_data,
    input  rx_rdy,
    input  frm_err
  );

  modport slave (
    input  RX,
    input  rider_off,
    output pwr_up,
    output rx_data,
    output rx_rdy,
    output frm_err
  );
endinterface

// File: rtl/auth_cmd_rx.sv
// rtl/auth_cmd_rx.sv - 8N1 UART command receiver driving the power-up authorization FSM
// Define AUTH_STOP_CHECK_EN to validate the stop bit and report framing errors on frm_err.
module auth_cmd_rx #(
  parameter int unsigned BAUD_DIV = 2604,
  parameter logic [7:0]  CMD_GO   = 8'h47,
  parameter logic [7:0]  CMD_STOP = 8'h53
) (
  input  logic         clk,
  input  logic         rst_n,
  auth_cmd_rx_if.slave bus
);

  localparam logic [15:0] BAUD_FULL = 16'(BAUD_DIV - 1);
  localparam logic [15:0] BAUD_HALF = 16'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;

  rx_state_t   rx_state, rx_state_nxt;
  auth_state_t auth, auth_nxt;

  logic        rx_s1, rx_s2, rx_prev;
  logic [15:0] baud_cnt, baud_cnt_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [7:0]  rx_data_q, rx_data_nxt;
  logic        rx_rdy_q, rx_rdy_nxt;
  logic        frm_err_q, frm_err_nxt;
  logic        pwr_up_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_state  <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data_q <= '0;
      rx_rdy_q  <= 1'b0;
      frm_err_q <= 1'b0;
      auth      <= OFF;
      pwr_up_q  <= 1'b0;
    end else begin
      rx_s1     <= bus.RX;
      rx_s2     <= rx_s1;
      rx_prev   <= rx_s2;
      rx_state  <= rx_state_nxt;
      baud_cnt  <= baud_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      rx_data_q <= rx_data_nxt;
      rx_rdy_q  <= rx_rdy_nxt;
      frm_err_q <= frm_err_nxt;
      auth      <= auth_nxt;
      // Decoded from the next state so pwr_up moves on the edge that closes the rx_rdy cycle.
      pwr_up_q  <= (auth_nxt != OFF);
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    baud_cnt_nxt = (baud_cnt != '0) ? baud_cnt - 16'd1 : baud_cnt;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift;
    rx_data_nxt  = rx_data_q;
    rx_rdy_nxt   = 1'b0;
    frm_err_nxt  = 1'b0;
    case (rx_state)
      IDLE: begin
        if (rx_prev && !rx_s2) begin
          rx_state_nxt = START;
          baud_cnt_nxt = BAUD_HALF;
        end
      end
      START: begin
        if (baud_cnt == '0) begin
          // A start bit that is high again at mid-bit was a glitch.
          rx_state_nxt = rx_s2 ? IDLE : DATA;
          baud_cnt_nxt = rx_s2 ? '0 : BAUD_FULL;
          bit_cnt_nxt  = '0;
        end
      end
      DATA: begin
        if (baud_cnt == '0) begin
          shift_nxt    = {rx_s2, shift[7:1]};
          baud_cnt_nxt = BAUD_FULL;
          if (bit_cnt == 3'd7) begin
            rx_state_nxt = STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_cnt == '0) begin
          rx_state_nxt = IDLE;
          baud_cnt_nxt = '0;
`ifdef AUTH_STOP_CHECK_EN
          if (rx_s2) begin
            rx_data_nxt = shift;
            rx_rdy_nxt  = 1'b1;
          end else begin
            frm_err_nxt = 1'b1;
          end
`else
          rx_data_nxt = shift;
          rx_rdy_nxt  = 1'b1;
`endif
        end
      end
      default: rx_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    auth_nxt = auth;
    case (auth)
      OFF: begin
        if (rx_rdy_q && rx_data_q == CMD_GO) auth_nxt = PWR1;
      end
      PWR1: begin
        if (rx_rdy_q && rx_data_q == CMD_STOP) auth_nxt = bus.rider_off ? OFF : PWR2;
      end
      PWR2: begin
        // A fresh GO outranks the rider stepping off in the same cycle.
        if (rx_rdy_q && rx_data_q == CMD_GO) auth_nxt = PWR1;
        else if (bus.rider_off)              auth_nxt = OFF;
      end
      default: auth_nxt = OFF;
    endcase
  end

  assign bus.pwr_up  = pwr_up_q;
  assign bus.rx_data = rx_data_q;
  assign bus.rx_rdy  = rx_rdy_q;
  assign bus.frm_err = frm_err_q;

endmodule

// File: tb/tb_auth_cmd_rx.sv
// tb/tb_auth_cmd_rx.sv - table-driven, scoreboarded bench for auth_cmd_rx
module tb_auth_cmd_rx;
  localparam int B   = 208;
  localparam int LAT = 3 + B / 2 + 9 * B;
  localparam int NV  = 20;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       ro;
    logic       raise;
    logic       exp_frm;
    logic       exp_pwr;
  } vec_t;

  typedef struct {
    logic       is_frm;
    logic [7:0] data;
    logic       pwr_before;
    logic       pwr_after;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;
  auth_cmd_rx_if bus ();

  auth_cmd_rx #(.BAUD_DIV(B), .CMD_GO(8'h47), .CMD_STOP(8'h53)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   start_cyc = 0;
  int   last_lat  = 0;
  int   pulses    = 0;
  sb_t  sbq[$];
  vec_t vecs[NV];
  logic cur_pwr   = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic chk_next  = 1'b0;
  logic exp_after = 1'b0;
  logic ro_base   = 1'b0;
  logic ro_raise  = 1'b0;
  logic raise_on_rdy = 1'b0;

  assign bus.rider_off = ro_base | ro_raise;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (!raise_on_rdy) ro_raise = 1'b0;
    else if (bus.rx_rdy) ro_raise = 1'b1;
    if (chk_next) begin
      chk_next = 1'b0;
      check("pwr_after_pulse", 32'(bus.pwr_up), 32'(exp_after));
      check("pulse_width", 32'({bus.rx_rdy, bus.frm_err}), 32'd0);
    end
    if (bus.rx_rdy || bus.frm_err) begin
      pulses++;
      if (sbq.size() == 0) begin
        check("unexpected_pulse", 32'({bus.rx_rdy, bus.frm_err}), 32'd0);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        last_lat = cyc - start_cyc;
        check("pulse_kind", 32'({bus.rx_rdy, bus.frm_err}), e.is_frm ? 32'd1 : 32'd2);
        check("rx_data", 32'(bus.rx_data), 32'(e.data));
        check("pwr_at_pulse", 32'(bus.pwr_up), 32'(e.pwr_before));
        exp_after = e.pwr_after;
        chk_next  = 1'b1;
      end
    end
  end

  task automatic push_exp(input logic [7:0] d, input logic is_frm, input logic pwr_after);
    sb_t e;
    e.is_frm     = is_frm;
    if (!is_frm) last_data = d;
    e.data       = last_data;
    e.pwr_before = cur_pwr;
    e.pwr_after  = pwr_after;
    cur_pwr      = pwr_after;
    sbq.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    @(posedge clk); #1;
    bus.RX = 1'b0;
    start_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      repeat (B) @(posedge clk);
      #1 bus.RX = d[i];
    end
    repeat (B) @(posedge clk);
    #1 bus.RX = stop_bit;
    repeat (B) @(posedge clk);
    #1 bus.RX = 1'b1;
    repeat (B) @(posedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || chk_next) && n < 4 * B) begin
      @(posedge clk);
      n++;
    end
    #1 check("scoreboard_drain", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #(10 * 120000);
    $display("FAIL watchdog: simulation did not finish, cycles %0d", cyc);
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{8'h47, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{8'h53, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{8'h41, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'h53, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{8'h47, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{8'h47, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{8'h53, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'h41, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{8'h47, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{8'h53, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef AUTH_STOP_CHECK_EN
    vecs[10] = '{8'h47, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    vecs[10] = '{8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
    vecs[11] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{8'h47, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{8'h53, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef AUTH_STOP_CHECK_EN
    vecs[15] = '{8'h47, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    vecs[15] = '{8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
    vecs[16] = '{8'h47, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{8'h53, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{8'h47, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[19] = '{8'h53, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n  = 1'b0;
    bus.RX = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("reset_pwr_up", 32'(bus.pwr_up), 32'd0);
    check("reset_rx_data", 32'(bus.rx_data), 32'd0);
    check("reset_rx_rdy", 32'(bus.rx_rdy), 32'd0);
    check("reset_frm_err", 32'(bus.frm_err), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Start-bit glitch shorter than half a bit time.
    begin
      int p0;
      p0 = pulses;
      @(posedge clk); #1 bus.RX = 1'b0;
      repeat (100) @(posedge clk);
      #1 bus.RX = 1'b1;
      repeat (3 * B) @(posedge clk);
      #1 check("glitch_no_pulse", 32'(pulses), 32'(p0));
    end

    for (int i = 0; i < NV; i++) begin
      ro_base      = vecs[i].ro;
      raise_on_rdy = vecs[i].raise;
      push_exp(vecs[i].data, vecs[i].exp_frm, vecs[i].exp_pwr);
      send_frame(vecs[i].data, vecs[i].stop_bit);
      drain();
      if (vecs[i].raise) begin
        ro_base      = 1'b1;
        raise_on_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("go_beats_rider_off", 32'(bus.pwr_up), 32'd1);
      end
      check("row_pwr_settled", 32'(bus.pwr_up), 32'(vecs[i].exp_pwr));
      if (i == 0) begin
        vectors++;
        if (last_lat < LAT - 3 || last_lat > LAT + 3) begin
          errors++;
          $display("FAIL start_to_rdy_latency: got %0d cycles, expected %0d +/- 3", last_lat, LAT);
        end
      end
      if (i == 1) begin
        @(posedge clk); #1;
        check("pwr2_before_rider_off", 32'(bus.pwr_up), 32'd1);
        ro_base = 1'b1;
        @(posedge clk); #1;
        check("pwr2_rider_off_drops", 32'(bus.pwr_up), 32'd0);
        cur_pwr = 1'b0;
      end
    end

    // Reset in the middle of the data bits while in PWR2.
    begin
      logic [7:0] d;
      int p0;
      d  = 8'h47;
      p0 = pulses;
      @(posedge clk); #1 bus.RX = 1'b0;
      for (int i = 0; i < 3; i++) begin
        repeat (B) @(posedge clk);
        #1 bus.RX = d[i];
      end
      repeat (B / 2) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("midrst_pwr_up", 32'(bus.pwr_up), 32'd0);
      check("midrst_rx_data", 32'(bus.rx_data), 32'd0);
      bus.RX = 1'b1;
      rst_n  = 1'b1;
      cur_pwr   = 1'b0;
      last_data = 8'h00;
      repeat (12 * B) @(posedge clk);
      #1 check("midrst_no_pulse", 32'(pulses), 32'(p0));
      push_exp(8'h47, 1'b0, 1'b1);
      send_frame(8'h47, 1'b1);
      drain();
      check("post_reset_go", 32'(bus.pwr_up), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/auth_cmd_rx.md
AUTH_CMD_RX -- requirements
Module: auth_cmd_rx

Interface
REQ-001 The block SHALL take parameter BAUD_DIV, default 2604, meaning clk cycles per UART bit (19200 baud at 50 MHz).
REQ-002 The block SHALL take parameter CMD_GO, default 8'h47, meaning power-up command byte ('G').
REQ-003 The block SHALL take parameter CMD_STOP, default 8'h53, meaning power-down command byte ('S').
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 RX  input  1  asynchronous UART serial line; idles high; 8N1, LSB first.
REQ-007 rider_off  input  1  high when the load cells report no rider.
REQ-008 pwr_up  output  1  registered enable to the balance controller and motor drive.
REQ-009 rx_data  output  8  last correctly framed byte received.
REQ-010 rx_rdy  output  1  one-cycle pulse when rx_data updates.
REQ-011 frm_err  output  1  one-cycle pulse on a stop-bit error.

Function
REQ-012 RX SHALL pass through a two-flop synchronizer; both flops reset to 1.
REQ-013 Receiver states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE -> START on a synchronized high-to-low transition of RX.
REQ-015 In START, RX SHALL be sampled after BAUD_DIV/2 cycles; RX low -> DATA, RX high -> IDLE (glitch rejection, no pulse).
REQ-016 In DATA, eight bits SHALL be sampled at successive BAUD_DIV intervals (mid-bit), shifted in LSB first; the bit counter SHALL count 0-7 and never wrap past 7.
REQ-017 In STOP, RX SHALL be sampled BAUD_DIV cycles after the last data bit; the receiver then returns to IDLE.
REQ-018 A valid stop bit SHALL load rx_data and pulse rx_rdy for exactly one cycle, on the cycle after the stop-bit sample.
REQ-019 The baud counter SHALL reload on every state entry and SHALL be wide enough for BAUD_DIV up to 65535.
REQ-020 A falling edge during DATA or STOP SHALL NOT restart reception.
REQ-021 Authorization states SHALL be OFF, PWR1 (powered, rider or not), PWR2 (stop requested, rider still on).
REQ-022 pwr_up SHALL be 0 in OFF and 1 in PWR1 and PWR2, registered from the state.
REQ-023 Transitions SHALL be evaluated only in an rx_rdy cycle, except PWR2 -> OFF.
REQ-024 OFF: rx_data==CMD_GO -> PWR1; any other byte ignored.
REQ-025 PWR1: CMD_STOP with rider_off=1 -> OFF; CMD_STOP with rider_off=0 -> PWR2; rider_off alone holds PWR1.
REQ-026 PWR2: rider_off=1 in any cycle -> OFF; CMD_GO -> PWR1; simultaneous CMD_GO and rider_off -> PWR1.
REQ-027 pwr_up SHALL change on the clock edge after the rx_rdy pulse that triggers it (one-cycle latency).
REQ-028 Unrecognized bytes SHALL still produce rx_rdy but SHALL NOT change authorization state.

Reset
REQ-029 With rst_n low at a clk edge: receiver IDLE, authorization OFF, pwr_up=0, rx_data=8'h00, rx_rdy=0, frm_err=0, synchronizer=1, counters=0.
REQ-030 Reset during any receiver state SHALL discard the partial byte with no rx_rdy or frm_err pulse.
REQ-031 After reset release, a frame whose start edge is already in progress SHALL be treated per REQ-015.

Configuration
REQ-032 Macro AUTH_STOP_CHECK_EN SHALL control stop-bit validation.
REQ-033 Defined: stop bit 0 SHALL pulse frm_err for one cycle, suppress rx_rdy, and leave rx_data and authorization state unchanged.
REQ-034 Undefined: the stop bit SHALL NOT be checked, every completed frame SHALL load rx_data and pulse rx_rdy, and frm_err SHALL be tied to 0.

Verification
REQ-035 Reset, then send 8'h47 with rider_off=0 -> rx_rdy pulse, rx_data=8'h47, pwr_up=1 one cycle after rx_rdy, about 24740 cycles after the start edge.
REQ-036 From PWR1, send 8'h53 with rider_off=0 -> pwr_up stays 1; set rider_off=1 -> pwr_up=0 on the next cycle.
REQ-037 From PWR1, set rider_off=1, then send 8'h53 -> pwr_up=0 one cycle after rx_rdy; then send 8'h41 -> rx_rdy pulses and pwr_up stays 0.
REQ-038 With AUTH_STOP_CHECK_EN defined, send 8'h47 with stop bit forced low -> frm_err pulse, no rx_rdy, pwr_up=0; without the macro -> rx_rdy pulses and pwr_up=1.
REQ-039 Drive an RX low glitch of 100 cycles -> no rx_rdy and no frm_err; then a full 8'h47 frame is received correctly.
REQ-040 Assert rst_n low mid-DATA of an 8'h47 frame from PWR2 -> pwr_up=0 and no pulses; the next full 8'h47 frame -> pwr_up=1.
